// File: rtl/vga_timing.sv
// Raster timing generator: pixel-rate divider, h/v counters and registered
// sync/active/coordinate/strobe outputs for the downstream colour stage.
module vga_timing #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          en,
    output logic          pix_en,
    output logic          hs,
    output logic          vs,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [DW-1:0] div, div_nxt;
    logic [CW-1:0] h_cnt, h_nxt;
    logic [CW-1:0] v_cnt, v_nxt;
    logic          act_d, hs_d, vs_d;

    // Pixel strobe decoded from the divider register; forced low while in reset
    assign pix_en = nReset && en && (div == DIV_LAST);

    // Next divider/counter values and output decode from pre-increment counts
    always_comb begin
        div_nxt = div;
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (en) begin
            div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
        end
        if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
            end else begin
                h_nxt = h_cnt + CW'(1);
            end
        end
        act_d = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
        hs_d  = ((h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END))) ? HS_POL : ~HS_POL;
        vs_d  = ((v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END))) ? VS_POL : ~VS_POL;
    end

    // State and output registers; strobes self-clear on any non-pixel clock
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            div         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div   <= div_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (pix_en) begin
                hs          <= hs_d;
                vs          <= vs_d;
                active      <= act_d;
                x           <= act_d ? h_cnt : '0;
                y           <= act_d ? v_cnt : '0;
                line_start  <= (h_cnt == '0);
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
            end else begin
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing on a small frame (15x8 pixels, CLK_DIV=4).
module tb_vga_timing;

    localparam int CD  = 4;
    localparam int HA  = 8, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA  = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT  = 15;
    localparam int VT  = 8;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int CW  = 5;
    localparam logic [14:0] RST_VEC = {1'b1, 1'b0, 1'b0, 10'd0, 2'd0};

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic          pix_en, hs, vs, active, line_start, frame_start;
    logic [CW-1:0] x, y;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // reference model state
    int          m_div = 0;
    int          m_p   = 0;
    logic [14:0] m_out = RST_VEC;
    logic [14:0] sb[$];

    vga_timing #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
    ) dut (
        .clk(clk), .nReset(nrst), .en(en), .pix_en(pix_en), .hs(hs), .vs(vs),
        .active(active), .x(x), .y(y), .line_start(line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] outv();
        return {hs, vs, active, x, y, line_start, frame_start};
    endfunction

    // Expected outputs for linear pixel index p within the frame
    function automatic logic [14:0] pix_out(input int p);
        int h, v;
        logic a, hb, vb;
        h  = p % HT;
        v  = p / HT;
        a  = (h < 8) && (v < 4);
        hb = (h >= 10 && h < 13) ? HSP : !HSP;
        vb = (v >= 5 && v < 7) ? VSP : !VSP;
        return {hb, vb, a, a ? 5'(h) : 5'd0, a ? 5'(v) : 5'd0, h == 0, p == 0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0;
        m_p   = 0;
        m_out = RST_VEC;
    endtask

    // One clock: inputs already set at the negedge; check strobe, edge, check outputs
    task automatic cyc(input string tag);
        logic pe;
        #1;
        pe = nrst && en && (m_div == CD - 1);
        check({tag, ".pix_en"}, 32'(pix_en), 32'(pe));
        if (!nrst) begin
            model_reset();
        end else begin
            if (pe) begin
                m_out = pix_out(m_p);
                m_p   = (m_p + 1) % (HT * VT);
            end else begin
                m_out[1:0] = 2'b00;
            end
            if (en) m_div = (m_div == CD - 1) ? 0 : m_div + 1;
        end
        sb.push_back(m_out);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".outs"}, 32'(outv()), 32'(sb.pop_front()));
        ncyc++;
    endtask

    initial begin
        int last_fs, last_ls, act_cnt, vs_cnt, hs_cnt, n0, k;
        logic [14:0] snap;

        // reset held
        @(negedge clk);
        check("rst_vals", 32'(outv()), 32'(RST_VEC));
        check("rst_pix_en", 32'(pix_en), 32'd0);
        cyc("rst");
        cyc("rst");

        // release with en=1: strobe in 4th cycle, pixel (0,0) after that edge
        nrst = 1'b1;
        en   = 1'b1;
        cyc("lat");
        cyc("lat");
        cyc("lat");
        #1;
        check("lat_pix_en4", 32'(pix_en), 32'd1);
        cyc("lat");
        check("lat_fs", 32'({frame_start, line_start, active}), 32'b111);
        check("lat_xy", 32'({x, y}), 32'd0);
        cyc("lat");
        check("lat_strobe_clr", 32'({frame_start, line_start}), 32'd0);
        check("lat_x_hold", 32'(x), 32'd0);

        // free run over two frame wraps, measuring periods from DUT outputs
        last_fs = -1; last_ls = -1; act_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc("run");
            if (line_start) begin
                if (last_ls >= 0) begin
                    check("line_period", 32'(ncyc - last_ls), 32'(HT * CD));
                    check("hs_width", 32'(hs_cnt), 32'(HSY * CD));
                end
                last_ls = ncyc;
                hs_cnt  = 0;
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    check("frame_period", 32'(ncyc - last_fs), 32'(HT * VT * CD));
                    check("active_clks", 32'(act_cnt), 32'(HA * VA * CD));
                    check("vs_width", 32'(vs_cnt), 32'(VSY * HT * CD));
                end
                last_fs = ncyc;
                act_cnt = 0;
                vs_cnt  = 0;
            end
            if (active) act_cnt++;
            if (vs == VSP) vs_cnt++;
            if (hs == HSP) hs_cnt++;
        end

        // freeze mid-line for 13 clks; line completes 13 clks late
        for (int i = 0; i < 600 && !(line_start && y == 5'd2); i++) cyc("wait_l2");
        check("wait_l2_found", 32'(line_start && y == 5'd2), 32'd1);
        n0 = ncyc;
        for (int i = 0; i < 100 && x != 5'd5; i++) cyc("wait_x5");
        check("wait_x5_found", 32'(x), 32'd5);
        en   = 1'b0;
        snap = outv();
        for (int i = 0; i < 13; i++) begin
            cyc("frz");
            check("frz_hold", 32'(outv()), 32'(snap));
        end
        en = 1'b1;
        for (int i = 0; i < 200 && !line_start; i++) cyc("resume");
        check("frz_line_period", 32'(ncyc - n0), 32'(HT * CD + 13));

        // asynchronous reset mid-frame, away from any clock edge
        for (int i = 0; i < 600 && !(line_start && y == 5'd3); i++) cyc("wait_l3");
        check("wait_l3_found", 32'(y), 32'd3);
        cyc("pre_rst");
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_vals", 32'(outv()), 32'(RST_VEC));
        check("async_rst_pix_en", 32'(pix_en), 32'd0);
        model_reset();
        @(negedge clk);
        cyc("rst2");
        cyc("rst2");
        nrst = 1'b1;
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            cyc("rel");
            if (frame_start) k = i;
        end
        check("rst_fs_latency", 32'(k), 32'(CD));
        for (int i = 0; i < 200; i++) cyc("tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator sitting directly upstream of the vga colour stage.
- Derives a pixel-rate enable from the system clock and runs horizontal/vertical counters over a parameterised frame.
- Produces hs, vs, active, pixel coordinates and line/frame strobes; the colour stage consumes these to drive r, g, b.
- All outputs are registered and mutually aligned, so the downstream stage needs no extra sync compensation.

Parameters:
- CLK_DIV, 4: system clocks per pixel (>=1); 4 gives 25 MHz from 100 MHz.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of hs.
- VS_POL, 0: asserted level of vs.
- CW, 10: counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- en  in  1  run enable; low freezes all timing.
- pix_en  out  1  one-clk pixel strobe.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- active  out  1  current pixel is in the visible region.
- x  out  CW  pixel column; 0 outside active.
- y  out  CW  pixel row; 0 outside active.
- line_start  out  1  one-clk pulse at pixel 0 of each line.
- frame_start  out  1  one-clk pulse at pixel (0,0) of each frame.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset (async, while nReset=0):
  - div=0, h_cnt=0, v_cnt=0.
  - pix_en=0, hs=!HS_POL, vs=!VS_POL.
  - active=0, x=0, y=0, line_start=0, frame_start=0.
- Divider:
  - div counts 0..CLK_DIV-1, wrapping to 0, and advances only while en=1.
  - pix_en = en && (div==CLK_DIV-1), decoded from registers.
  - CLK_DIV=1 gives pix_en=en.
- Counters, on each clk edge with pix_en=1:
  - h_cnt wraps at H_TOTAL-1 to 0.
  - On h_cnt wrap, v_cnt increments, wrapping at V_TOTAL-1 to 0.
- Output registers load only on clk edges with pix_en=1, decoded from pre-increment (h_cnt, v_cnt):
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - x = active ? h : 0; y = active ? v : 0.
  - hs = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vs = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else !VS_POL. vs is line-aligned: it changes with the h=0 load.
  - line_start = (h==0); frame_start = (h==0 && v==0).
- Output timing:
  - hs, vs, active, x, y hold for CLK_DIV clks (one pixel).
  - line_start and frame_start are cleared on the next clk edge, so they are one clk wide regardless of CLK_DIV.
- Latency:
  - After reset release with en=1, pix_en is first high in the CLK_DIV-th cycle.
  - Pixel (0,0) outputs are valid after that edge, with frame_start=1.
- en low mid-frame:
  - div, counters and all outputs hold.
  - pix_en=0; line_start/frame_start still clear after one clk.
  - Timing resumes exactly where it stopped.
- Reset mid-frame returns immediately to reset values; the next frame restarts at (0,0).
- Wrap boundaries:
  - h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 is the last pixel of the frame.
  - The next pix_en yields frame_start with no gap pixel.
- Constraint: H_SYNC, V_SYNC, CLK_DIV >= 1; no other degenerate-parameter support.

Test Plan:
- Defaults, 100 MHz clk, en=1 after reset:
  - Line period 3200 clks; hs low for 384 clks starting at x-pixel 656.
  - active high for 2560 clks per visible line.
- Defaults, full frame:
  - frame_start pulses every 1,680,000 clks.
  - vs low for 6400 clks starting at the line_start of line 490.
  - x/y sequence 0..639 / 0..479 during active, 0 outside.
- Small params (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, both POL=1):
  - Frame = 48 clks.
  - hs high at h=5,6; vs high for 8 clks at v=4.
  - active count = 12 clks per frame.
- Latency, CLK_DIV=4:
  - Release nReset with en=1: pix_en high in cycle 4; after edge 4, x=0, y=0, active=1, line_start=frame_start=1.
  - Both strobes low one clk later; x stays 0 until edge 8.
- en low for 50 clks at h=100, v=10:
  - Outputs frozen (x=99 or 100 per alignment), no pix_en.
  - After en=1, the line completes with total clks = 3200+50.
- nReset pulsed at v=300:
  - All outputs return to reset values asynchronously, before the next clk edge.
  - Next frame_start occurs CLK_DIV clks after release.
